if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the IF stage. It owns the PC, sequences single-outstanding read requests to the instruction cache port, and buffers returned words in a small FIFO. It presents the buffered instruction and PC to the decoder/ID boundary with a valid/ready handshake. Taken branches and jumps from EX redirect it, which flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0060, PC fetched first after reset
QDEPTH, 2, instruction FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (asserted when 0)
imem_read  out  1  read request to I-cache
imem_address  out  32  word-aligned fetch address
imem_resp  in  1  one-cycle pulse; read complete
imem_rdata  in  32  instruction word, valid with imem_resp
redirect  in  1  EX taken branch/jump, one-cycle pulse
redirect_pc  in  32  redirect target
id_ready  in  1  ID accepts if_instr this cycle
if_valid  out  1  FIFO head valid
if_instr  out  32  FIFO head instruction
if_pc  out  32  FIFO head PC

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH, pc=RESET_PC, FIFO empty, imem_read=0, if_valid=0, if_instr=0, if_pc=0. First cycle after release: imem_read=1, imem_address=RESET_PC.
- States:
  - FETCH: request outstanding; imem_read=1.
  - HOLD: FIFO full, no request; imem_read=0.
  - DROP: request outstanding whose data is to be discarded; imem_read=1.
- Request protocol: imem_read and imem_address stay stable from assertion until the cycle imem_resp=1. At most one request is outstanding. imem_read drops for exactly one cycle after each resp.
- Issue rule: a new request issues in the cycle after a resp, or after leaving HOLD, only if FIFO count < QDEPTH. Otherwise go to HOLD. HOLD goes to FETCH in the cycle after a dequeue makes space.
- FETCH + imem_resp (no redirect): enqueue {pc, imem_rdata}; pc <= pc+4, mod 2^32, wrap silently. Entry visible at if_valid one cycle after resp.
- Dequeue: occurs when if_valid && id_ready. Head advances next cycle. Simultaneous enqueue and dequeue leaves count unchanged.
- Redirect, evaluated every cycle with priority over all else:
  - FIFO cleared next cycle; any same-cycle dequeue or enqueue is ignored.
  - if_valid is forced 0 in the redirect cycle.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - In HOLD, or FETCH with imem_resp=1 in the same cycle: next cycle FETCH at the new pc.
  - In FETCH without resp: next cycle DROP.
  - In DROP: pc updates, and state stays DROP.
- DROP + imem_resp: data discarded, nothing enqueued; next cycle FETCH at pc. In DROP, imem_address holds the old in-flight address until resp; it never changes mid-request.
- FIFO pointers are log2(QDEPTH) bits and wrap. Count is log2(QDEPTH)+1 bits, 0..QDEPTH.
- Outputs if_instr and if_pc come from the head register. They are 0 when empty.
- Reset mid-request: all state is cleared immediately. A later stray imem_resp while imem_read=0 is ignored, in every state.

Decomposition:
- Shared package rv32i_types: fetch_state_t enum {FETCH, HOLD, DROP}, fetch_entry_t struct {pc[31:0], instr[31:0]}, constant RESET_PC default.
- One sub-module: fetch_queue, a parameterised QDEPTH FIFO of fetch_entry_t with push/pop/flush, full/empty/count, and the same clk/rst.
- The controller FSM and PC logic stay in if_fetch_ctrl.

Test Plan:
- Reset then id_ready=1, I-cache responds 1 cycle after each request with 0x00000013: addresses 0x60, 0x64, 0x68 in order; if_valid rises 1 cycle after first resp with if_pc=0x60, if_instr=0x00000013.
- id_ready=0 with responses flowing: after 2 enqueues, state=HOLD and imem_read=0. id_ready=1 for one cycle: if_pc 0x60 dequeued, then the next cycle imem_read=1 at 0x68.
- redirect=1, redirect_pc=0x1003 while a request to 0x64 is outstanding without resp: next cycle if_valid=0 and state=DROP; resp data for 0x64 is never presented; next request address=0x1000.
- redirect coincident with imem_resp for 0x64: data dropped; next cycle imem_read=1 at redirect target; FIFO empty.
- redirect_pc=0xFFFFFFFC, sequential fetches: addresses 0xFFFFFFFC then 0x00000000 (wrap).
- rst pulled low while a request is outstanding, then a stray imem_resp during reset: no enqueue; after release, first fetch is at 0x60 with if_valid=0.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared types for the instruction-fetch slice: controller states,
// the buffered fetch entry, and the default boot PC.
package rv32i_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0060;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_ctrl_fetch_queue.sv
// Small power-of-two FIFO of fetch entries with a flush that wins over
// push/pop. The head reads as zero whenever the queue is empty.
module fetch_queue
  import rv32i_types::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [63:0]               push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [63:0]               head_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(QDEPTH):0]   count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(QDEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head_data = empty ? 64'd0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= fetch_entry_t'(push_data);
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, keeps one I-cache read in flight,
// buffers returned words and hands them to ID; EX redirects flush everything.
module if_fetch_ctrl
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_read,
  output logic [31:0]             imem_address,
  input  logic                    imem_resp,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    id_ready,
  output logic                    if_valid,
  output logic [31:0]             if_instr,
  output logic [31:0]             if_pc,
  output logic [1:0]              dbg_state,
  output logic [$clog2(QDEPTH):0] dbg_count
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic         resp_v;
  logic         push;
  logic         pop;
  logic         space;
  logic         q_full;
  logic         q_empty;
  logic [63:0]  head_data;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         unused_bits;

  // Handshake: an entry moves to ID on any cycle where if_valid && id_ready.
  // A response only counts while our read is actually asserted.
  assign resp_v     = imem_resp && imem_read;
  assign if_valid   = !q_empty && !redirect;
  assign pop        = if_valid && id_ready;
  assign push       = (state == FETCH) && resp_v && !redirect;
  assign space      = !q_full || pop;
  assign target     = {redirect_pc[31:2], 2'b00};
  assign push_entry = '{pc: pc, instr: imem_rdata};
  assign head       = fetch_entry_t'(head_data);
  assign if_instr   = head.instr;
  assign if_pc      = head.pc;
  assign dbg_state  = state;
  assign unused_bits = ^redirect_pc[1:0];

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect),
    .head_data (head_data),
    .full      (q_full),
    .empty     (q_empty),
    .count     (dbg_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      imem_read    <= 1'b0;
      imem_address <= '0;
    end else if (redirect) begin
      pc <= target;
      // A read still in flight must finish before the new PC can go out.
      if (imem_read && !imem_resp) begin
        state <= DROP;
      end else begin
        state        <= FETCH;
        imem_read    <= 1'b1;
        imem_address <= target;
      end
    end else begin
      case (state)
        FETCH: begin
          if (resp_v) begin
            pc        <= pc + 32'd4;
            imem_read <= 1'b0;
          end else if (!imem_read) begin
            if (space) begin
              imem_read    <= 1'b1;
              imem_address <= pc;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (space) begin
            state        <= FETCH;
            imem_read    <= 1'b1;
            imem_address <= pc;
          end
        end
        DROP: begin
          if (resp_v) begin
            state     <= FETCH;
            imem_read <= 1'b0;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed reset/hold sequences, then a random
// I-cache and redirect stream checked against a PC-stream reference model.
module tb_if_fetch_ctrl;
  import rv32i_types::*;

  localparam logic [31:0] RPC = 32'h0000_0060;

  logic        clk;
  logic        rst;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  if_fetch_ctrl #(.RESET_PC(RPC), .QDEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .id_ready     (id_ready),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .dbg_state    (dbg_state),
    .dbg_count    (dbg_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          passes = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  bit          mon_en = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // scoreboard monitor: every word ID accepts must be the next expected one
  always @(negedge clk) begin
    if (mon_en) begin
      if (redirect) begin
        check("valid_on_redirect", {63'd0, if_valid}, 64'd0);
      end else if (if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL deq_unexpected: got pc %h instr %h expected no entry", if_pc, if_instr);
        end else begin
          exp_e = exp_q.pop_front();
          check("deq_entry", {if_pc, if_instr}, exp_e);
        end
      end else if (!if_valid) begin
        check("empty_outputs", {if_pc, if_instr}, 64'd0);
      end
    end
  end

  logic [31:0] next_fetch;
  logic [31:0] cur_addr;
  logic [31:0] tgt;
  bit          out_req;
  bit          dead;
  bit          drop_pending;
  bit          gap_chk;
  bit          stall;
  bit          resp;
  bit          stray;
  bit          redir;
  int          lat;

  initial begin
    rst = 1'b0;
    imem_resp = 1'b0;
    imem_rdata = '0;
    redirect = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    repeat (2) step();
    check("rst_read", {63'd0, imem_read}, 64'd0);
    check("rst_valid", {63'd0, if_valid}, 64'd0);
    check("rst_head", {if_pc, if_instr}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, {62'd0, FETCH});
    check("rst_count", {62'd0, dbg_count}, 64'd0);

    // first fetches with ID stalled: fill the queue, reach HOLD
    rst = 1'b1;
    step();
    check("boot_req", {31'd0, imem_read, imem_address}, {31'd0, 1'b1, RPC});
    step();
    imem_resp = 1'b1; imem_rdata = 32'h0000_0013;
    step();
    imem_resp = 1'b0;
    check("first_valid", {63'd0, if_valid}, 64'd1);
    check("first_head", {if_pc, if_instr}, {RPC, 32'h0000_0013});
    check("read_drop", {63'd0, imem_read}, 64'd0);
    step();
    check("second_req", {31'd0, imem_read, imem_address}, {31'd0, 1'b1, RPC + 32'd4});
    step();
    imem_resp = 1'b1;
    step();
    imem_resp = 1'b0;
    step();
    check("hold_state", {62'd0, dbg_state}, {62'd0, HOLD});
    check("hold_read", {63'd0, imem_read}, 64'd0);
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    check("resume_req", {31'd0, imem_read, imem_address}, {31'd0, 1'b1, RPC + 32'd8});
    check("head_advanced", {32'd0, if_pc}, {32'd0, RPC + 32'd4});

    // reset mid-request with a stray response straddling the release
    rst = 1'b0;
    #1;
    check("midrst_clear", {62'd0, imem_read, if_valid}, 64'd0);
    imem_resp = 1'b1; imem_rdata = 32'hdead_beef;
    step();
    step();
    rst = 1'b1;
    step();
    imem_resp = 1'b0;
    check("rerun_req", {31'd0, imem_read, imem_address}, {31'd0, 1'b1, RPC});
    check("rerun_valid", {63'd0, if_valid}, 64'd0);

    // random phase: I-cache model, redirects, ID back-pressure
    next_fetch = RPC;
    out_req = 0; dead = 0; drop_pending = 0; gap_chk = 0; stall = 0;
    mon_en = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (drop_pending) check("drop_state", {62'd0, dbg_state}, {62'd0, DROP});
      if (gap_chk) check("read_gap", {63'd0, imem_read}, 64'd0);
      drop_pending = 0;
      if (imem_read && !out_req) begin
        check("req_addr", {32'd0, imem_address}, {32'd0, next_fetch});
        out_req = 1;
        cur_addr = imem_address;
        lat = $urandom_range(0, 2);
      end else if (out_req) begin
        check("req_stable", {31'd0, imem_read, imem_address}, {31'd0, 1'b1, cur_addr});
      end
      resp = 0; stray = 0;
      if (out_req) begin
        if (lat == 0) resp = 1;
        else lat--;
      end else if ($urandom_range(0, 7) == 0) begin
        stray = 1;
      end
      redir = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: tgt = 32'h0000_1003;
        1: tgt = 32'hffff_fffc;
        2: tgt = 32'hffff_fff4;
        default: tgt = $urandom;
      endcase
      if (cyc % 64 == 0) stall = ($urandom_range(0, 2) == 0);
      id_ready = stall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      imem_resp = resp | stray;
      imem_rdata = resp ? mem_word(cur_addr) : $urandom;
      redirect = redir;
      redirect_pc = tgt;
      if (resp) begin
        if (!dead && !redir) begin
          exp_q.push_back({cur_addr, mem_word(cur_addr)});
          next_fetch = cur_addr + 32'd4;
        end
        dead = 0;
        out_req = 0;
      end
      if (redir) begin
        exp_q.delete();
        next_fetch = {tgt[31:2], 2'b00};
        if (out_req) begin
          dead = 1;
          drop_pending = 1;
        end
      end
      gap_chk = resp && !redir;
      step();
    end

    // drain: no more responses, ID always ready
    imem_resp = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b1;
    repeat (20) step();
    check("drain_empty", {32'd0, exp_q.size()}, 64'd0);
    mon_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
